// File: rtl/game_outcome_ctrl.sv
// game_outcome_ctrl: Avalon-MM slave that runs one game round.
// It counts lives, holds the player invulnerable after a non-fatal hit,
// latches win/lose and interrupts the CPU when the round is over.
// Software starts and acknowledges rounds through the CTRL register.
module game_outcome_ctrl #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        hit_pulse,
  input  logic        goal_pulse,
  output logic        lose_out,
  output logic        win_out,
  output logic        playing,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  // Bus handshake: a write is accepted in the single cycle where
  // chipselect is high and write_n is low; there is no wait request,
  // and readdata is valid in the same cycle as address.
  logic             wr;
  logic             ctrl_wr;
  logic             init_wr;
  logic             start;
  logic             ack;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       lives;
  logic [3:0]       lives_nxt;
  logic [3:0]       lives_init;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic             lose_nxt;
  logic             win_nxt;
  logic             enter_over;
  logic             irq_en;
  logic             irq_pending;
  logic             hold_done;
  logic             last_life;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr & (address == 2'd0);
  assign init_wr   = wr & (address == 2'd2);
  assign start     = ctrl_wr & writedata[0];
  assign ack       = ctrl_wr & writedata[1];
  assign hold_done = (timer == '0);
  assign last_life = (lives <= 4'd1);

  assign playing = (state == S_PLAY) || (state == S_HOLD);
  assign irq     = irq_pending & irq_en;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; goal outranks hit, ack outranks start in OVER.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_PLAY;
      S_PLAY: begin
        if (goal_pulse)     state_nxt = S_OVER;
        else if (hit_pulse) state_nxt = last_life ? S_OVER : S_HOLD;
      end
      S_HOLD: begin
        if (goal_pulse)     state_nxt = S_OVER;
        else if (hold_done) state_nxt = S_PLAY;
      end
      default: if (ack) state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values: lives, hold timer and outcome flags.
  always_comb begin
    lives_nxt  = lives;
    timer_nxt  = timer;
    lose_nxt   = lose_out;
    win_nxt    = win_out;
    case (state)
      S_IDLE: if (start) lives_nxt = (lives_init == 4'd0) ? 4'd1 : lives_init;
      S_PLAY: begin
        if (goal_pulse) begin
          win_nxt = 1'b1;
        end else if (hit_pulse) begin
          lives_nxt = last_life ? 4'd0 : lives - 4'd1;
          if (last_life) lose_nxt  = 1'b1;
          else           timer_nxt = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      S_HOLD: begin
        if (goal_pulse) begin
          win_nxt   = 1'b1;
          timer_nxt = '0;
        end else if (!hold_done) begin
          timer_nxt = timer - CNT_W'(1);
        end
      end
      default: begin
        if (ack) begin
          lose_nxt = 1'b0;
          win_nxt  = 1'b0;
        end
      end
    endcase
    enter_over = (state != S_OVER) && (state_nxt == S_OVER);
  end

  // Datapath registers; entering OVER sets the pending flag over any ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lives       <= 4'd0;
      timer       <= '0;
      lose_out    <= 1'b0;
      win_out     <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      lives    <= lives_nxt;
      timer    <= timer_nxt;
      lose_out <= lose_nxt;
      win_out  <= win_nxt;
      if (enter_over) irq_pending <= 1'b1;
      else if (ack)   irq_pending <= 1'b0;
    end
  end

  // Software-written configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en     <= 1'b0;
      lives_init <= 4'd3;
    end else begin
      if (ctrl_wr) irq_en     <= writedata[2];
      if (init_wr) lives_init <= writedata[3:0];
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {29'd0, irq_en, 2'b00};
      2'd1:    readdata = {23'd0, irq_pending, lives, win_out, lose_out, state};
      2'd2:    readdata = {28'd0, lives_init};
      default: readdata = 32'(timer);
    endcase
  end

endmodule

// File: tb/tb_game_outcome_ctrl.sv
// Bench for game_outcome_ctrl: directed scenarios plus a randomized run
// checked against a cycle-count based model of the round rules.
module tb_game_outcome_ctrl;

  localparam int H  = 4;
  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        hit_pulse;
  logic        goal_pulse;
  logic        lose_out;
  logic        win_out;
  logic        playing;
  logic        irq;

  int checks = 0;
  int fails  = 0;

  // Model: state as 0..3, hold tracked as the cycle index at which play resumes.
  int m_state, m_lives, m_init, m_hold_until, cyc;
  bit m_irq_en, m_pend, m_lose, m_win;

  game_outcome_ctrl #(.HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .hit_pulse(hit_pulse), .goal_pulse(goal_pulse), .lose_out(lose_out),
    .win_out(win_out), .playing(playing), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_init = 3; m_irq_en = 0;
    m_pend = 0; m_lose = 0; m_win = 0; m_hold_until = 0;
  endtask

  task automatic model_step(input bit wr, input int a, input logic [31:0] wd,
                            input bit hit, input bit goal);
    bit start, ack;
    int prev;
    start = wr && (a == 0) && wd[0];
    ack   = wr && (a == 0) && wd[1];
    prev  = m_state;
    case (m_state)
      0: if (start) begin m_state = 1; m_lives = (m_init == 0) ? 1 : m_init; end
      1: begin
        if (goal) begin m_state = 3; m_win = 1; end
        else if (hit) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin m_state = 3; m_lose = 1; end
          else begin m_state = 2; m_hold_until = cyc + H; end
        end
      end
      2: begin
        if (goal) begin m_state = 3; m_win = 1; end
        else if (cyc == m_hold_until) m_state = 1;
      end
      default: if (ack) begin m_state = 0; m_lose = 0; m_win = 0; end
    endcase
    if (ack) m_pend = 0;
    if (m_state == 3 && prev != 3) m_pend = 1;
    if (wr && a == 0) m_irq_en = wd[2];
    if (wr && a == 2) m_init = int'(wd[3:0]);
  endtask

  function automatic logic [31:0] exp_status();
    return {23'd0, m_pend, 4'(m_lives), m_win, m_lose, 2'(m_state)};
  endfunction

  function automatic logic [31:0] exp_hold();
    return (m_state == 2) ? 32'(m_hold_until - cyc - 1) : 32'd0;
  endfunction

  function automatic logic [3:0] exp_outs();
    return {m_lose, m_win, (m_state == 1 || m_state == 2), m_pend & m_irq_en};
  endfunction

  // Clock/cycle driver: inputs are sampled just before the edge by the model.
  task automatic cycle();
    bit wr, h, g;
    int a;
    logic [31:0] wd;
    wr = chipselect && !write_n; a = int'(address); wd = writedata;
    h = hit_pulse; g = goal_pulse;
    @(posedge clk);
    cyc++;
    if (reset_n) model_step(wr, a, wd, h, g);
    else model_reset();
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic pulse(input bit h, input bit g);
    hit_pulse = h; goal_pulse = g;
    cycle();
    hit_pulse = 1'b0; goal_pulse = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_regs [4];
    exp_regs[0] = 32'h0; exp_regs[1] = 32'h0; exp_regs[2] = 32'h3; exp_regs[3] = 32'h0;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; hit_pulse = 1'b0; goal_pulse = 1'b0;
    cyc = 0; model_reset();
    #12 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      checks++;
      if (d !== exp_regs[i]) begin
        fails++; $display("FAIL reset_reg%0d: got %h expected %h", i, d, exp_regs[i]);
      end
    end
    checks++;
    if ({lose_out, win_out, playing, irq} !== 4'b0000) begin
      fails++; $display("FAIL reset_outs: got %b expected 0000", {lose_out, win_out, playing, irq});
    end
  endtask

  task automatic test_lose_sequence();
    logic [31:0] d;
    int hold_cnt;
    wr_reg(2'd0, 32'h5);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h31) begin fails++; $display("FAIL start_status: got %h expected 31", d); end
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0);
      hold_cnt = 0;
      for (int j = 0; j < 6; j++) begin
        rd(2'd1, d);
        if (d[1:0] == 2'd2) hold_cnt++;
        checks++;
        if (d !== exp_status()) begin
          fails++; $display("FAIL seq_status hit%0d c%0d: got %h expected %h", k, j, d, exp_status());
        end
        checks++;
        if (d[7:4] !== 4'(2 - k)) begin
          fails++; $display("FAIL seq_lives hit%0d: got %0d expected %0d", k, d[7:4], 2 - k);
        end
        rd(2'd3, d);
        checks++;
        if (d !== exp_hold()) begin
          fails++; $display("FAIL seq_hold hit%0d c%0d: got %h expected %h", k, j, d, exp_hold());
        end
        if (j < 5) cycle();
      end
      checks++;
      if (hold_cnt !== ((k < 2) ? H : 0)) begin
        fails++; $display("FAIL hold_length hit%0d: got %0d expected %0d", k, hold_cnt, (k < 2) ? H : 0);
      end
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h107) begin fails++; $display("FAIL lose_status: got %h expected 107", d); end
    checks++;
    if ({lose_out, win_out, irq} !== 3'b101) begin
      fails++; $display("FAIL lose_outs: got %b expected 101", {lose_out, win_out, irq});
    end
    wr_reg(2'd0, 32'h2);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL ack_status: got %h expected 0", d); end
    checks++;
    if ({lose_out, win_out, playing, irq} !== 4'b0000) begin
      fails++; $display("FAIL ack_outs: got %b expected 0000", {lose_out, win_out, playing, irq});
    end
  endtask

  task automatic test_hold_hit_goal();
    logic [31:0] d;
    wr_reg(2'd0, 32'h1);
    pulse(1'b1, 1'b0);
    cycle();
    pulse(1'b1, 1'b0);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h22) begin fails++; $display("FAIL hold_hit_ignored: got %h expected 22", d); end
    pulse(1'b0, 1'b1);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h12B) begin fails++; $display("FAIL hold_goal_status: got %h expected 12b", d); end
    checks++;
    if ({lose_out, win_out, playing} !== 3'b010) begin
      fails++; $display("FAIL hold_goal_outs: got %b expected 010", {lose_out, win_out, playing});
    end
    wr_reg(2'd0, 32'h2);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    wr_reg(2'd2, 32'h1);
    wr_reg(2'd0, 32'h1);
    pulse(1'b1, 1'b1);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h11B) begin fails++; $display("FAIL simul_status: got %h expected 11b", d); end
    checks++;
    if ({lose_out, win_out} !== 2'b01) begin
      fails++; $display("FAIL simul_outs: got %b expected 01", {lose_out, win_out});
    end
    wr_reg(2'd0, 32'h2);
  endtask

  task automatic test_lives_init();
    logic [31:0] d;
    wr_reg(2'd2, 32'h0);
    wr_reg(2'd0, 32'h1);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h11) begin fails++; $display("FAIL init_zero: got %h expected 11", d); end
    pulse(1'b0, 1'b1);
    wr_reg(2'd0, 32'h2);
    wr_reg(2'd2, 32'h1F);
    rd(2'd2, d);
    checks++;
    if (d !== 32'hF) begin fails++; $display("FAIL init_trunc: got %h expected f", d); end
    wr_reg(2'd2, 32'h3);
  endtask

  task automatic test_ack_start();
    logic [31:0] d;
    wr_reg(2'd0, 32'h1);
    wr_reg(2'd0, 32'h1);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h31) begin fails++; $display("FAIL start_in_play: got %h expected 31", d); end
    pulse(1'b0, 1'b1);
    wr_reg(2'd0, 32'h3);
    cycle();
    rd(2'd1, d);
    checks++;
    if (d !== 32'h30) begin fails++; $display("FAIL ack_with_start: got %h expected 30", d); end
    checks++;
    if (playing !== 1'b0) begin fails++; $display("FAIL ack_with_start_playing: got %b expected 0", playing); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      writedata = $urandom;
      address = 2'($urandom_range(0, 3));
      if (r < 12) begin
        if ($urandom_range(0, 1) == 1) address = 2'd0;
        chipselect = 1'b1; write_n = 1'b0;
      end else if (r < 16) begin
        chipselect = 1'b0; write_n = 1'b0;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
      end
      hit_pulse  = ($urandom_range(0, 99) < 20);
      goal_pulse = ($urandom_range(0, 99) < 5);
      cycle();
      chipselect = 1'b0; write_n = 1'b1; hit_pulse = 1'b0; goal_pulse = 1'b0;
      rd(2'd1, d);
      checks++;
      if (d !== exp_status()) begin
        fails++; $display("FAIL rand_status i=%0d: got %h expected %h", i, d, exp_status());
      end
      rd(2'd3, d);
      checks++;
      if (d !== exp_hold()) begin
        fails++; $display("FAIL rand_hold i=%0d: got %h expected %h", i, d, exp_hold());
      end
      rd(2'd0, d);
      checks++;
      if (d !== {29'd0, m_irq_en, 2'b00}) begin
        fails++; $display("FAIL rand_ctrl i=%0d: got %h expected %h", i, d, {29'd0, m_irq_en, 2'b00});
      end
      checks++;
      if ({lose_out, win_out, playing, irq} !== exp_outs()) begin
        fails++; $display("FAIL rand_outs i=%0d: got %b expected %b", i, {lose_out, win_out, playing, irq}, exp_outs());
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [31:0] d;
    reset_n = 1'b0; #2; reset_n = 1'b1; model_reset();
    wr_reg(2'd0, 32'h5);
    pulse(1'b1, 1'b0);
    cycle();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({lose_out, win_out, playing, irq} !== 4'b0000) begin
      fails++; $display("FAIL midhold_reset_outs: got %b expected 0000", {lose_out, win_out, playing, irq});
    end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL midhold_reset_timer: got %h expected 0", d); end
    hit_pulse = 1'b1; goal_pulse = 1'b1;
    cycle();
    hit_pulse = 1'b0; goal_pulse = 1'b0;
    reset_n = 1'b1;
    cycle();
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL post_reset_status: got %h expected 0", d); end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL post_reset_ctrl: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_lose_sequence();
    test_hold_hit_goal();
    test_simultaneous();
    test_lives_init();
    test_ack_start();
    test_random();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/game_outcome_ctrl.md
Name: game_outcome_ctrl

Overview:
- Avalon-MM slave controller that sequences the game's win/lose outcome flags.
- Counts lives, applies a post-hit invulnerability hold and latches win or lose.
- Drives the lose/win outputs that were previously written directly by software through a bare PIO.
- Raises an interrupt to the Nios II on game over; software starts and acknowledges rounds through registers.

Parameters:
- HOLD_CYCLES, 50000000: invulnerability hold after a non-fatal hit, in clk cycles (1 s at 50 MHz); must be at least 1.
- CNT_W, 26: hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational from address
- hit_pulse  in  1  one-cycle player-hit event, clk-synchronous
- goal_pulse  in  1  one-cycle goal-reached event, clk-synchronous
- lose_out  out  1  lose flag
- win_out  out  1  win flag
- playing  out  1  high in PLAY or HOLD
- irq  out  1  level interrupt, irq_pending & irq_en

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE, lives=0, lives_init=3, irq_en=0, irq_pending=0, timer=0.
  - lose_out=0, win_out=0, playing=0, irq=0.
- Write occurs when chipselect & ~write_n. Reads have zero wait states. Unused readdata bits are 0.
- Register map:
  - addr 0, CTRL: W bit0 start, bit1 ack, bit2 irq_en (stored). Read returns irq_en in bit2.
  - addr 1, STATUS: read-only; [1:0] state, [2] lose, [3] win, [7:4] lives, [8] irq_pending.
  - addr 2, LIVES_INIT: RW, 4 bits, writedata[3:0]. Writable in any state; takes effect at the next start.
  - addr 3, HOLD_REMAIN: read-only; timer value, zero-extended.
- State encodings: IDLE=0, PLAY=1, HOLD=2, OVER=3.
- IDLE:
  - start -> PLAY next cycle.
  - lives <= lives_init; lives_init=0 is loaded as 1.
- PLAY:
  - goal_pulse -> OVER, win_out=1.
  - hit_pulse with lives==1 -> lives=0, OVER, lose_out=1.
  - hit_pulse with lives>1 -> lives-1, HOLD, timer=HOLD_CYCLES-1.
  - Simultaneous hit and goal: goal has priority; win, lives unchanged.
- HOLD:
  - hit_pulse ignored.
  - goal_pulse -> OVER, win_out=1.
  - Otherwise timer decrements each cycle; at timer==0 -> PLAY.
  - HOLD lasts exactly HOLD_CYCLES cycles.
- OVER:
  - irq_pending set on the entry cycle.
  - ack -> IDLE: clears lose_out, win_out, irq_pending; lives retained for readback.
  - start ignored, including when written together with ack (ack wins; a separate start is required).
- start outside IDLE is ignored.
- ack outside OVER clears irq_pending only.
- irq_en change takes effect on irq the next cycle.
- lose_out and win_out are never both 1. Both are registered outputs with no glitches.
- Reset mid-round returns to the reset values immediately; pulses during reset are ignored.

Test Plan:
- Reset, then read all addresses -> CTRL=0x0, STATUS=0x000, LIVES_INIT=0x3, HOLD_REMAIN=0; all outputs 0.
- HOLD_CYCLES=4; write CTRL=0x5 (start + irq_en); three hit_pulses each spaced 6 cycles apart:
  - STATUS lives goes 3->2->1->0.
  - HOLD lasts 4 cycles after each of the first two hits.
  - Third hit -> lose_out=1, state=3, irq=1.
  - Write CTRL=0x2 -> IDLE, irq=0, lose_out=0.
- A hit during HOLD is ignored (lives unchanged). A goal during HOLD -> win_out=1, state=3.
- hit_pulse and goal_pulse in the same cycle with lives=1 -> win_out=1, lose_out=0, lives=1.
- LIVES_INIT=0 then start -> lives=1. LIVES_INIT=0x1F -> reads back 0xF.
- In OVER, write CTRL=0x3 -> IDLE, not PLAY. Start in PLAY -> no change. Assert reset_n=0 mid-HOLD -> all outputs 0 immediately.
